dmem_responder: RTL and testbench
=================================

# dmem_responder

Data-memory responder: the memory-side end of the core's load/store interface. Accepts one LSU request at a time (op encoded as `lsu_ls_t`), waits a configurable number of cycles, then performs the byte-lane-steered access to an internal byte-addressable array. It returns sign- or zero-extended load data, or an error for misaligned or out-of-range accesses. It sits between the LSU and data storage and stands in for a slow on-chip SRAM or bus target.

## Interface
- `XLEN`, 32, data and address width
- `DMEM_MEM_SIZE`, 4096, memory size in bytes; must be a power of two and a multiple of 4
- `LATENCY`, 2, wait cycles between acceptance and response; legal range 0..15

- `clk`  in  1  clock
- `rst`  in  1  synchronous, active-high reset
- `req_valid`  in  1  request present
- `req_ready`  out  1  responder can accept a request
- `req_op`  in  4 (`lsu_ls_t`)  LSU_LOAD_B/H/W/BU/HU, LSU_STORE_B/H/W, LSU_NONE
- `req_addr`  in  XLEN  byte address
- `req_wdata`  in  XLEN  store data; low byte/half/word is used per op
- `rsp_valid`  out  1  response present
- `rsp_ready`  in  1  consumer takes the response
- `rsp_rdata`  out  XLEN  load result; 0 for stores, LSU_NONE and errors
- `rsp_err`  out  1  misaligned or out-of-range access

## Operation
- FSM states: IDLE, WAIT, RESP. `rst` forces IDLE; memory contents are not cleared.
- IDLE: `req_ready`=1. When `req_valid`&&`req_ready`, capture op/addr/wdata and load the wait counter with LATENCY.
  - If LATENCY=0, go to RESP.
  - Otherwise go to WAIT.
- WAIT: `req_ready`=0. Decrement the counter each cycle. When the counter reaches 1, go to RESP.
- The access is performed on the clock edge that enters RESP, using the captured request. When LATENCY=0, it uses the request at the acceptance edge.
- Error check:
  - Out of range: `addr >= DMEM_MEM_SIZE`.
  - Misaligned: H/HU ops with `addr[0]`=1; W ops with `addr[1:0]`≠0.
  - On error: `rsp_err`=1, `rsp_rdata`=0, no write.
- Loads read byte lanes `addr..addr+n-1` (little-endian).
  - B and H are sign-extended from bit 7 or 15.
  - BU and HU are zero-extended.
- Stores write 1, 2 or 4 bytes from the low bits of wdata. All other bytes are unchanged. `rsp_rdata`=0.
- LSU_NONE: accepted and responded normally, `rsp_err`=0, `rsp_rdata`=0, no access.
- Undefined op encodings (9..15) are treated as LSU_NONE with `rsp_err`=1.
- RESP: `rsp_valid`=1. `rsp_rdata` and `rsp_err` are stable until `rsp_valid`&&`rsp_ready`, after which the FSM returns to IDLE.
- No request is accepted in RESP or WAIT.

## Timing
- Reset values, on the first edge with `rst`=1: state IDLE, `req_ready`=1, `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0, counter 0.
- Acceptance edge = cycle 0. `rsp_valid` rises in cycle LATENCY+1.
- Handshake completion at edge E; `req_ready`=1 in the cycle after E.
- Maximum throughput is one request per LATENCY+2 cycles when `rsp_ready` is held high.
- `rsp_ready` low stalls indefinitely in RESP; outputs hold.
- A load immediately following a store to the same address returns the stored data, because the write commits before the next request is accepted.
- Reset mid-operation:
  - In WAIT: the pending access is dropped; no write occurs.
  - In RESP: the response is discarded; a store already committed remains in memory.
- `req_valid` asserted while `rst`=1 is ignored.
- `req_*` inputs may change freely after acceptance; only captured values are used.

## Test plan
- LATENCY=2, store_w 0xDEADBEEF at 0x10, then load_w 0x10 → `rsp_valid` in cycle 3 after each accept, rdata 0xDEADBEEF, err 0.
- After the word store: load_b 0x13 → 0xFFFFFFDE; load_bu 0x13 → 0x000000DE; load_h 0x12 → 0xFFFFDEAD; load_hu 0x10 → 0x0000BEEF.
- store_b 0x5A at 0x11 over 0xDEADBEEF → load_w 0x10 returns 0xDEAD5AEF; store_h 0x1234 at 0x12 → 0x12345AEF.
- Errors, each with no write:
  - load_w 0x102 → err=1, rdata 0.
  - store_h at 0x21 → err=1; memory unchanged.
  - load_b at 0x1000 (DMEM_MEM_SIZE=4096) → err=1.
  - op=LSU_NONE → err=0, rdata 0.
- Backpressure and throughput: hold `rsp_ready`=0 for 5 cycles in RESP → outputs stable, `req_ready`=0, a second `req_valid` is not accepted. Repeat with LATENCY=0 and `rsp_ready`=1 → back-to-back accepts every 2 cycles.
- Assert `rst` in the WAIT of store_w 0xCAFEBABE at 0x40 (prior content 0) → next cycle IDLE, `rsp_valid`=0, `req_ready`=1; a following load_w 0x40 returns 0x00000000.

Source files
------------

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one LSU request, waits LATENCY cycles, then performs a
// byte-lane-steered load/store on an internal byte array and holds the response until taken.
module dmem_responder #(
   parameter int XLEN          = 32,
   parameter int DMEM_MEM_SIZE = 4096,
   parameter int LATENCY       = 2
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic [3:0]      req_op,
   input  logic [XLEN-1:0] req_addr,
   input  logic [XLEN-1:0] req_wdata,
   output logic            rsp_valid,
   input  logic            rsp_ready,
   output logic [XLEN-1:0] rsp_rdata,
   output logic            rsp_err
);
   // state | meaning
   // IDLE  | ready for a request
   // WAIT  | request captured, counting down LATENCY
   // RESP  | response held until rsp_ready
   localparam int AW = $clog2(DMEM_MEM_SIZE);

   typedef enum logic [3:0] {
      LSU_LOAD_B   = 4'd0,
      LSU_LOAD_H   = 4'd1,
      LSU_LOAD_W   = 4'd2,
      LSU_LOAD_BU  = 4'd3,
      LSU_LOAD_HU  = 4'd4,
      LSU_STORE_B  = 4'd5,
      LSU_STORE_H  = 4'd6,
      LSU_STORE_W  = 4'd7,
      LSU_NONE     = 4'd8
   } lsu_ls_t;

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t          state;
   logic [3:0]      cnt;
   logic [3:0]      cap_op;
   logic [XLEN-1:0] cap_addr;
   logic [XLEN-1:0] cap_wdata;
   logic [7:0]      mem [DMEM_MEM_SIZE];

   logic [3:0]      acc_op;
   logic [XLEN-1:0] acc_addr;
   logic [XLEN-1:0] acc_wdata;
   logic [AW-1:0]   idx;
   logic [7:0]      b0, b1, b2, b3;
   logic            acc_err, mis, undef_op, oor;
   logic [3:0]      acc_we;
   logic [XLEN-1:0] acc_rdata;
   logic            accept, do_access;

   assign accept    = req_valid && req_ready;
   assign do_access = (state == IDLE && accept && LATENCY == 0) ||
                      (state == WAIT && cnt == 4'd1);

   // With zero latency the access happens on the acceptance edge, so use the live request.
   always_comb begin
      acc_op    = (LATENCY == 0) ? req_op    : cap_op;
      acc_addr  = (LATENCY == 0) ? req_addr  : cap_addr;
      acc_wdata = (LATENCY == 0) ? req_wdata : cap_wdata;
      idx       = acc_addr[AW-1:0];
      b0        = mem[idx];
      b1        = mem[idx + AW'(1)];
      b2        = mem[idx + AW'(2)];
      b3        = mem[idx + AW'(3)];
      oor       = acc_addr >= XLEN'(DMEM_MEM_SIZE);
      mis       = 1'b0;
      undef_op  = 1'b0;
      acc_we    = 4'b0000;
      acc_rdata = '0;
      case (acc_op)
         LSU_LOAD_B:  acc_rdata = {{(XLEN-8){b0[7]}}, b0};
         LSU_LOAD_BU: acc_rdata = {{(XLEN-8){1'b0}}, b0};
         LSU_LOAD_H: begin
            mis       = acc_addr[0];
            acc_rdata = {{(XLEN-16){b1[7]}}, b1, b0};
         end
         LSU_LOAD_HU: begin
            mis       = acc_addr[0];
            acc_rdata = {{(XLEN-16){1'b0}}, b1, b0};
         end
         LSU_LOAD_W: begin
            mis       = acc_addr[1:0] != 2'b00;
            acc_rdata = XLEN'({b3, b2, b1, b0});
         end
         LSU_STORE_B: acc_we = 4'b0001;
         LSU_STORE_H: begin
            mis    = acc_addr[0];
            acc_we = 4'b0011;
         end
         LSU_STORE_W: begin
            mis    = acc_addr[1:0] != 2'b00;
            acc_we = 4'b1111;
         end
         LSU_NONE: ;
         default: undef_op = 1'b1;
      endcase
      acc_err = oor || mis || undef_op;
      if (acc_err) begin
         acc_rdata = '0;
         acc_we    = 4'b0000;
      end
   end

   // Storage is never cleared by reset; only the write itself is gated.
   always_ff @(posedge clk) begin
      if (!rst && do_access) begin
         for (int k = 0; k < 4; k++) begin
            if (acc_we[k]) mem[idx + AW'(k)] <= acc_wdata[8*k +: 8];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         req_ready <= 1'b1;
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
         cnt       <= 4'd0;
         cap_op    <= 4'd0;
         cap_addr  <= '0;
         cap_wdata <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  cap_op    <= req_op;
                  cap_addr  <= req_addr;
                  cap_wdata <= req_wdata;
                  cnt       <= 4'(LATENCY);
                  req_ready <= 1'b0;
                  if (LATENCY == 0) begin
                     state     <= RESP;
                     rsp_valid <= 1'b1;
                     rsp_rdata <= acc_rdata;
                     rsp_err   <= acc_err;
                  end else begin
                     state <= WAIT;
                  end
               end
            end
            WAIT: begin
               if (cnt == 4'd1) begin
                  state     <= RESP;
                  rsp_valid <= 1'b1;
                  rsp_rdata <= acc_rdata;
                  rsp_err   <= acc_err;
                  cnt       <= 4'd0;
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            RESP: begin
               if (rsp_ready) begin
                  state     <= IDLE;
                  rsp_valid <= 1'b0;
                  req_ready <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: a LATENCY=2 instance driven from a vector table plus
// hand sequences, and a LATENCY=0 instance for back-to-back throughput.
module tb_dmem_responder;
   localparam logic [3:0] LB = 4'd0, LH = 4'd1, LW = 4'd2, LBU = 4'd3, LHU = 4'd4;
   localparam logic [3:0] SB = 4'd5, SH = 4'd6, SW = 4'd7, NONE = 4'd8;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  req_op;
   logic [31:0] req_addr, req_wdata;
   logic        v2, rr2, rv2, rdy2, err2;
   logic [31:0] rd2;
   logic        v0, rr0, rv0, rdy0, err0;
   logic [31:0] rd0;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   dmem_responder #(.XLEN(32), .DMEM_MEM_SIZE(4096), .LATENCY(2)) dut2 (
      .clk(clk), .rst(rst), .req_valid(v2), .req_ready(rdy2), .req_op(req_op),
      .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rv2), .rsp_ready(rr2),
      .rsp_rdata(rd2), .rsp_err(err2));

   dmem_responder #(.XLEN(32), .DMEM_MEM_SIZE(4096), .LATENCY(0)) dut0 (
      .clk(clk), .rst(rst), .req_valid(v0), .req_ready(rdy0), .req_op(req_op),
      .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rv0), .rsp_ready(rr0),
      .rsp_rdata(rd0), .rsp_err(err0));

   typedef struct {
      logic [3:0]  op;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_rdata;
      logic        exp_err;
   } vec_t;

   vec_t vecs[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic [3:0] op, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [31:0] exp_rdata,
                               input logic exp_err);
      vec_t v;
      v.op = op; v.addr = addr; v.wdata = wdata; v.exp_rdata = exp_rdata; v.exp_err = exp_err;
      return v;
   endfunction

   // One full transaction on the selected instance (sel 2 or 0); lat counts cycles
   // from the acceptance edge until rsp_valid is seen.
   task automatic txn(input int sel, input logic [3:0] op, input logic [31:0] addr,
                      input logic [31:0] wdata, output logic [31:0] rdata,
                      output logic err, output int lat);
      logic vis;
      @(negedge clk);
      req_op = op; req_addr = addr; req_wdata = wdata;
      if (sel == 2) v2 = 1'b1; else v0 = 1'b1;
      @(posedge clk);
      #1;
      v2 = 1'b0; v0 = 1'b0;
      req_op = 4'($urandom_range(0, 15)); req_addr = $urandom; req_wdata = $urandom;
      lat = 0;
      vis = 1'b0;
      rdata = '0;
      err = 1'b0;
      while (!vis && lat < 20) begin
         @(negedge clk);
         lat++;
         vis = (sel == 2) ? rv2 : rv0;
      end
      if (!vis) begin
         chk("rsp_valid timeout", 32'(lat), 32'(sel + 1));
      end else begin
         rdata = (sel == 2) ? rd2 : rd0;
         err   = (sel == 2) ? err2 : err0;
         if (sel == 2) rr2 = 1'b1; else rr0 = 1'b1;
         @(posedge clk);
         #1;
         rr2 = 1'b0; rr0 = 1'b0;
      end
   endtask

   initial begin
      logic [31:0] rdata;
      logic        err;
      int          lat;
      int          n_rdy, n_rv;

      rst = 1'b1; v2 = 1'b0; v0 = 1'b0; rr2 = 1'b0; rr0 = 1'b0;
      req_op = NONE; req_addr = '0; req_wdata = '0;

      vecs.push_back(mk(SW,  32'h10,   32'hDEADBEEF, 32'h0,        1'b0));
      vecs.push_back(mk(LW,  32'h10,   32'h0,        32'hDEADBEEF, 1'b0));
      vecs.push_back(mk(LB,  32'h13,   32'h0,        32'hFFFFFFDE, 1'b0));
      vecs.push_back(mk(LBU, 32'h13,   32'h0,        32'h000000DE, 1'b0));
      vecs.push_back(mk(LH,  32'h12,   32'h0,        32'hFFFFDEAD, 1'b0));
      vecs.push_back(mk(LHU, 32'h10,   32'h0,        32'h0000BEEF, 1'b0));
      vecs.push_back(mk(SB,  32'h11,   32'hFFFFFF5A, 32'h0,        1'b0));
      vecs.push_back(mk(LW,  32'h10,   32'h0,        32'hDEAD5AEF, 1'b0));
      vecs.push_back(mk(SH,  32'h12,   32'hFFFF1234, 32'h0,        1'b0));
      vecs.push_back(mk(LW,  32'h10,   32'h0,        32'h12345AEF, 1'b0));
      vecs.push_back(mk(SW,  32'h20,   32'h11223344, 32'h0,        1'b0));
      vecs.push_back(mk(SH,  32'h21,   32'h0000FFFF, 32'h0,        1'b1));
      vecs.push_back(mk(LW,  32'h20,   32'h0,        32'h11223344, 1'b0));
      vecs.push_back(mk(LW,  32'h102,  32'h0,        32'h0,        1'b1));
      vecs.push_back(mk(LB,  32'h1000, 32'h0,        32'h0,        1'b1));
      vecs.push_back(mk(NONE,32'h10,   32'hFFFFFFFF, 32'h0,        1'b0));
      vecs.push_back(mk(4'd9,32'h10,   32'h0,        32'h0,        1'b1));
      vecs.push_back(mk(SW,  32'h0,    32'h01020304, 32'h0,        1'b0));
      vecs.push_back(mk(SW,  32'h1000, 32'hAAAAAAAA, 32'h0,        1'b1));
      vecs.push_back(mk(LW,  32'h0,    32'h0,        32'h01020304, 1'b0));
      vecs.push_back(mk(SB,  32'h23,   32'h000000AB, 32'h0,        1'b0));
      vecs.push_back(mk(LW,  32'h20,   32'h0,        32'hAB223344, 1'b0));
      vecs.push_back(mk(LH,  32'h22,   32'h0,        32'hFFFFAB22, 1'b0));
      vecs.push_back(mk(LHU, 32'h22,   32'h0,        32'h0000AB22, 1'b0));
      vecs.push_back(mk(LB,  32'h21,   32'h0,        32'h00000033, 1'b0));
      vecs.push_back(mk(LHU, 32'h23,   32'h0,        32'h0,        1'b1));
      vecs.push_back(mk(SW,  32'h40,   32'h0,        32'h0,        1'b0));

      // reset values
      @(posedge clk);
      @(negedge clk);
      chk("reset req_ready", 32'(rdy2), 32'd1);
      chk("reset rsp_valid", 32'(rv2), 32'd0);
      chk("reset rsp_rdata", rd2, 32'h0);
      chk("reset rsp_err",   32'(err2), 32'd0);
      rst = 1'b0;

      foreach (vecs[i]) begin
         txn(2, vecs[i].op, vecs[i].addr, vecs[i].wdata, rdata, err, lat);
         chk($sformatf("vec%0d rdata", i), rdata, vecs[i].exp_rdata);
         chk($sformatf("vec%0d err", i), 32'(err), 32'(vecs[i].exp_err));
         chk($sformatf("vec%0d latency", i), 32'(lat), 32'd3);
      end

      // backpressure: response held 5 cycles while a second request waits
      @(negedge clk);
      req_op = LW; req_addr = 32'h10; v2 = 1'b1;
      @(posedge clk);
      #1;
      req_op = SW; req_addr = 32'h10; req_wdata = 32'h00000BAD;
      begin
         int k = 0;
         while (!rv2 && k < 20) begin
            @(negedge clk);
            k++;
         end
      end
      chk("bp rsp_valid rise", 32'(rv2), 32'd1);
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         chk($sformatf("bp hold%0d rsp_valid", c), 32'(rv2), 32'd1);
         chk($sformatf("bp hold%0d rdata", c), rd2, 32'h12345AEF);
         chk($sformatf("bp hold%0d req_ready", c), 32'(rdy2), 32'd0);
      end
      v2 = 1'b0; rr2 = 1'b1;
      @(posedge clk);
      #1 rr2 = 1'b0;
      @(negedge clk);
      chk("bp after rsp_valid", 32'(rv2), 32'd0);
      chk("bp after req_ready", 32'(rdy2), 32'd1);
      txn(2, LW, 32'h10, 32'h0, rdata, err, lat);
      chk("bp second req not taken", rdata, 32'h12345AEF);

      // reset during WAIT drops the store
      @(negedge clk);
      req_op = SW; req_addr = 32'h40; req_wdata = 32'hCAFEBABE; v2 = 1'b1;
      @(posedge clk);
      #1 v2 = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("rst-wait rsp_valid", 32'(rv2), 32'd0);
      chk("rst-wait req_ready", 32'(rdy2), 32'd1);
      txn(2, LW, 32'h40, 32'h0, rdata, err, lat);
      chk("rst-wait no write", rdata, 32'h0);

      // req_valid during reset is ignored
      txn(2, SW, 32'h80, 32'h55, rdata, err, lat);
      @(negedge clk);
      rst = 1'b1; v2 = 1'b1; req_op = SW; req_addr = 32'h80; req_wdata = 32'h99;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0; v2 = 1'b0;
      chk("rst-valid rsp_valid", 32'(rv2), 32'd0);
      txn(2, LW, 32'h80, 32'h0, rdata, err, lat);
      chk("rst-valid ignored", rdata, 32'h55);

      // LATENCY=0 instance
      txn(0, SW, 32'h44, 32'h87654321, rdata, err, lat);
      chk("lat0 store latency", 32'(lat), 32'd1);
      txn(0, LB, 32'h44, 32'h0, rdata, err, lat);
      chk("lat0 load_b rdata", rdata, 32'h00000021);
      chk("lat0 load_b latency", 32'(lat), 32'd1);
      txn(0, LW, 32'h44, 32'h0, rdata, err, lat);
      chk("lat0 load_w rdata", rdata, 32'h87654321);

      @(negedge clk);
      req_op = SW; req_addr = 32'h48; req_wdata = 32'h0; v0 = 1'b1; rr0 = 1'b1;
      n_rdy = 0; n_rv = 0;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         if (rdy0) n_rdy++;
         if (rv0) n_rv++;
      end
      v0 = 1'b0;
      @(negedge clk);
      rr0 = 1'b0;
      chk("lat0 b2b accepts", 32'(n_rdy), 32'd4);
      chk("lat0 b2b responses", 32'(n_rv), 32'd4);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global timeout: got running expected finished");
      $fatal(1, "timeout");
   end
endmodule
